// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - PDM mic clock generator, boxcar decimator and 2-entry sample FIFO
module pdm_decimator #(
  parameter int CLK_DIV  = 25,
  parameter int DEC_LEN  = 32,
  parameter int SAMPLE_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                record_en,
  input  logic                mic_data,
  output logic                mic_clk,
  output logic                mic_lrsel,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                overrun_flag
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DEC_LEN > 1) ? $clog2(DEC_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DEC_LEN - 1);

  logic [1:0]          sync_q, sync_d;
  logic                rec_q, rec_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                mic_clk_q, mic_clk_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W-1:0] head_q, head_d;
  logic [SAMPLE_W-1:0] tail_q, tail_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                overrun_q, overrun_d;
  logic                overrun_flag_q, overrun_flag_d;

  logic                push;
  logic                pop;
  logic [SAMPLE_W-1:0] push_val;

  // Mic clock divider and window accumulator; everything idles at zero while not recording
  always_comb begin
    sync_d    = {sync_q[0], mic_data};
    rec_d     = record_en;
    div_cnt_d = '0;
    mic_clk_d = 1'b0;
    bit_cnt_d = '0;
    acc_d     = '0;
    push      = 1'b0;
    push_val  = acc_q + SAMPLE_W'(sync_q[1]);
    if (record_en) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      mic_clk_d = mic_clk_q;
      bit_cnt_d = bit_cnt_q;
      acc_d     = acc_q;
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        mic_clk_d = ~mic_clk_q;
        // The falling mic_clk edge is the sampling point for the synchronized bit
        if (mic_clk_q) begin
          if (bit_cnt_q == BIT_LAST) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            acc_d     = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            acc_d     = push_val;
          end
        end
      end
    end
  end

  // Output FIFO: pop is applied first so a push into a full buffer that is draining still fits
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    pop       = (cnt_q != 2'd0) && sample_ready;
    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) begin
        head_d = push_val;
        cnt_d  = 2'd1;
      end else if (cnt_d == 2'd1) begin
        tail_d = push_val;
        cnt_d  = 2'd2;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Sticky overrun indicator, cleared when a new recording starts
  always_comb begin
    overrun_flag_d = overrun_flag_q;
    if (record_en && !rec_q) begin
      overrun_flag_d = 1'b0;
    end else if (overrun_d) begin
      overrun_flag_d = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q         <= '0;
      rec_q          <= 1'b0;
      div_cnt_q      <= '0;
      mic_clk_q      <= 1'b0;
      bit_cnt_q      <= '0;
      acc_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      cnt_q          <= '0;
      overrun_q      <= 1'b0;
      overrun_flag_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      rec_q          <= rec_d;
      div_cnt_q      <= div_cnt_d;
      mic_clk_q      <= mic_clk_d;
      bit_cnt_q      <= bit_cnt_d;
      acc_q          <= acc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      cnt_q          <= cnt_d;
      overrun_q      <= overrun_d;
      overrun_flag_q <= overrun_flag_d;
    end
  end

  assign mic_clk      = mic_clk_q;
  assign mic_lrsel    = 1'b1;
  assign sample_data  = head_q;
  assign sample_valid = (cnt_q != 2'd0);
  assign overrun      = overrun_q;
  assign overrun_flag = overrun_flag_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb/tb_pdm_decimator.sv - self-checking bench for pdm_decimator
module tb_pdm_decimator;

  localparam int CLK_DIV  = 25;
  localparam int DEC_LEN  = 32;
  localparam int SAMPLE_W = 6;
  localparam int PER      = 2 * CLK_DIV;
  localparam int NB       = 256;

  logic                clk = 1'b0;
  logic                reset;
  logic                record_en;
  logic                mic_data;
  logic                mic_clk;
  logic                mic_lrsel;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready;
  logic                overrun;
  logic                overrun_flag;

  int n_checks = 0;
  int n_fail   = 0;

  bit bits[NB];

  // Reference model: time since recording start, expected sample queue
  int m_k = 0;
  int m_q[$];
  bit m_ov = 0;
  bit m_flag = 0;
  bit m_rec = 0;
  bit m_clk = 0;
  int m_pre;
  bit m_pop;
  bit m_push;
  int m_val;

  int got[$];
  int ov_cnt = 0;

  pdm_decimator #(.CLK_DIV(CLK_DIV), .DEC_LEN(DEC_LEN), .SAMPLE_W(SAMPLE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .record_en    (record_en),
    .mic_data     (mic_data),
    .mic_clk      (mic_clk),
    .mic_lrsel    (mic_lrsel),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_flag (overrun_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int window_sum(input int first);
    int s = 0;
    for (int i = 0; i < DEC_LEN; i++) s += int'(bits[(first + i) % NB]);
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k = 0;
      m_q.delete();
      m_ov = 0;
      m_flag = 0;
      m_rec = 0;
      m_clk = 0;
    end else begin
      m_pre  = m_q.size();
      m_pop  = (m_pre > 0) && sample_ready;
      m_push = 0;
      m_val  = 0;
      if (record_en) begin
        if (!m_rec) m_flag = 0;
        m_k++;
        if (m_k % (PER * DEC_LEN) == 0) begin
          m_push = 1;
          m_val  = window_sum(m_k / PER - DEC_LEN);
        end
      end else begin
        m_k = 0;
      end
      m_rec = record_en;
      m_clk = record_en && (((m_k / CLK_DIV) % 2) == 1);
      if (m_pop) void'(m_q.pop_front());
      m_ov = 0;
      if (m_push) begin
        if (m_pre == 2 && !m_pop) begin
          m_ov   = 1;
          m_flag = 1;
        end else begin
          m_q.push_back(m_val);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mic_clk", mic_clk, m_clk);
    chk("mic_lrsel", mic_lrsel, 1);
    chk("sample_valid", sample_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("sample_data", sample_data, m_q[0]);
    chk("overrun", overrun, m_ov);
    chk("overrun_flag", overrun_flag, m_flag);
    if (sample_valid && sample_ready) got.push_back(int'(sample_data));
    if (overrun) ov_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!sample_valid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("valid_seen", sample_valid, 1);
  endtask

  task automatic fill(input int mode);
    logic [31:0] pat;
    pat = 32'h0BCA9C74;
    for (int i = 0; i < NB; i++) begin
      case (mode)
        0: bits[i] = 1'b1;
        1: bits[i] = (i < 32) ? pat[i] : 1'b0;
        2: bits[i] = (i >= 32 && i < 64) ? 1'b0 : 1'b1;
        default: bits[i] = (i < 32) ? ((i % 4) == 0) : 1'b1;
      endcase
    end
  endtask

  initial begin
    int n;
    int n2;
    reset = 1'b1;
    record_en = 1'b0;
    mic_data = 1'b0;
    sample_ready = 1'b0;
    fill(0);
    fork
      forever begin
        @(posedge clk);
        #1;
        mic_data = bits[(m_k / PER) % NB];
      end
    join_none

    // Reset and idle
    step(3);
    reset = 1'b0;
    step(100);
    chk("idle_mic_clk", mic_clk, 0);
    chk("idle_valid", sample_valid, 0);
    chk("idle_flag", overrun_flag, 0);
    chk("idle_lrsel", mic_lrsel, 1);
    chk("idle_data", sample_data, 0);

    // All ones
    fill(0);
    sample_ready = 1'b1;
    record_en = 1'b1;
    n = 0;
    while (!mic_clk && n < 100) begin
      step(1);
      n++;
    end
    chk("first_rise", n, 25);
    wait_valid(2000, n2);
    chk("first_latency", n + n2, 1600);
    chk("ones_value", sample_data, 32);
    step(1);
    chk("valid_one_cycle", sample_valid, 0);
    wait_valid(2000, n);
    chk("sample_interval", n + 1, 1600);
    chk("ones_value2", sample_data, 32);
    record_en = 1'b0;
    step(3);

    // Pattern 0x0BCA9C74
    fill(1);
    record_en = 1'b1;
    wait_valid(2000, n);
    chk("pattern_value", sample_data, 15);
    record_en = 1'b0;
    step(3);

    // Backpressure and overrun
    fill(2);
    sample_ready = 1'b0;
    got.delete();
    ov_cnt = 0;
    record_en = 1'b1;
    step(3 * 1600 + 10);
    chk("bp_overrun_pulses", ov_cnt, 1);
    chk("bp_flag_set", overrun_flag, 1);
    chk("bp_valid_held", sample_valid, 1);
    chk("bp_head", sample_data, 32);
    record_en = 1'b0;
    sample_ready = 1'b1;
    step(4);
    chk("bp_drained", got.size(), 2);
    chk("bp_first", (got.size() > 0) ? got[0] : -1, 32);
    chk("bp_second", (got.size() > 1) ? got[1] : -1, 0);
    chk("bp_flag_kept", overrun_flag, 1);
    record_en = 1'b1;
    step(1);
    chk("bp_flag_cleared", overrun_flag, 0);
    record_en = 1'b0;
    step(2);

    // Abort after 10 bits
    fill(0);
    got.delete();
    record_en = 1'b1;
    step(530);
    chk("abort_mic_clk_hi", mic_clk, 1);
    record_en = 1'b0;
    step(1);
    chk("abort_mic_clk_lo", mic_clk, 0);
    step(2000);
    chk("abort_no_sample", got.size(), 0);
    fill(3);
    record_en = 1'b1;
    wait_valid(2000, n);
    chk("abort_full_window", n, 1600);
    chk("abort_value", sample_data, 8);
    record_en = 1'b0;
    step(3);

    // Asynchronous reset mid-window with a held sample
    fill(0);
    sample_ready = 1'b0;
    got.delete();
    record_en = 1'b1;
    step(2460);
    chk("mid_valid_before", sample_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mic_clk", mic_clk, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_flag", overrun_flag, 0);
    sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_valid(2000, n);
    chk("rst_new_window", n, 1600);
    chk("rst_value", sample_data, 32);
    chk("rst_no_stale", got.size(), 0);
    record_en = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, meaning clk cycles per mic_clk half-period (2 MHz mic_clk from 100 MHz clk).
REQ-002 SHALL have parameter DEC_LEN, default 32, meaning PDM bits summed per output sample.
REQ-003 SHALL have parameter SAMPLE_W, default 6, meaning sample width; must satisfy 2^SAMPLE_W > DEC_LEN.
REQ-004 SHALL have port clk  input  1  system clock; the block has one clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port record_en  input  1  record enable level, synchronous to clk.
REQ-007 SHALL have port mic_data  input  1  PDM bit from microphone, asynchronous to clk.
REQ-008 SHALL have port mic_clk  output  1  generated microphone clock.
REQ-009 SHALL have port mic_lrsel  output  1  channel select, constant 1.
REQ-010 SHALL have port sample_data  output  SAMPLE_W  decimated sample (count of 1s in window).
REQ-011 SHALL have port sample_valid  output  1  sample_data holds a valid sample.
REQ-012 SHALL have port sample_ready  input  1  consumer accepts sample.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed sample is dropped.
REQ-014 SHALL have port overrun_flag  output  1  sticky overrun indicator.

Function
REQ-015 SHALL pass mic_data through a 2-flop synchronizer; the sampled bit is the synchronizer output.
REQ-016 SHALL, while record_en=1, count div_cnt 0..CLK_DIV-1 and toggle mic_clk on each terminal count; first mic_clk rise CLK_DIV cycles after record_en rises.
REQ-017 SHALL define the sampling edge as the clk edge where mic_clk is driven 1->0; on it, add the sampled bit to acc and increment bit_cnt.
REQ-018 SHALL, on the sampling edge with bit_cnt=DEC_LEN-1, push acc+bit into the output buffer and clear acc and bit_cnt in that same edge.
REQ-019 SHALL, while record_en=0, hold mic_clk=0, div_cnt=0, bit_cnt=0, acc=0; an incomplete window is discarded; buffered samples are kept and remain drainable.
REQ-020 SHALL implement a 2-entry FIFO output buffer; sample_valid=1 when non-empty; sample_data = oldest entry.
REQ-021 SHALL transfer a sample when sample_valid and sample_ready are both 1 at a clk edge; sample_data stable while sample_valid=1 and sample_ready=0.
REQ-022 SHALL assert sample_valid in the cycle after the pushing sampling edge (latency 1 clk).
REQ-023 SHALL, on push with buffer full and no pop, drop the new sample, pulse overrun for 1 cycle, set overrun_flag.
REQ-024 SHALL, on push and pop in the same cycle with buffer full, accept the push (no overrun).
REQ-025 SHALL clear overrun_flag on the clk edge where record_en rises 0->1.
REQ-026 SHALL keep sample value in range 0..DEC_LEN with no wrap.

Reset
REQ-027 SHALL, on reset=1, asynchronously clear synchronizer, div_cnt, bit_cnt, acc, FIFO, mic_clk, sample_valid, sample_data, overrun, overrun_flag to 0; mic_lrsel stays 1.
REQ-028 SHALL resume only with a full new window after reset deasserts and record_en=1; reset mid-window discards that window.

Verification
REQ-029 SHALL verify reset: reset=1 then 0, record_en=0 -> mic_clk=0, sample_valid=0, overrun_flag=0, mic_lrsel=1 indefinitely.
REQ-030 SHALL verify all-ones: record_en=1, mic_data=1, sample_ready=1 -> first mic_clk rise 25 clk after record_en, sample_data=32 valid 1 cycle, new sample every 1600 clk.
REQ-031 SHALL verify pattern: bits of 0x0BCA9C74 LSB-first, one per mic_clk period -> sample_data=15.
REQ-032 SHALL verify backpressure: sample_ready=0 over three windows with data 1,0,1 -> samples 32,0 held, third dropped, overrun pulse, overrun_flag=1; then sample_ready=1 -> 32 then 0 delivered in order, flag stays 1 until record_en re-rises.
REQ-033 SHALL verify abort: record_en dropped after 10 bits -> no sample, mic_clk=0 next cycle; record_en re-raised -> next sample counts exactly 32 new bits.
REQ-034 SHALL verify async reset mid-operation: reset pulsed with sample_valid=1 and bit_cnt=17 -> all outputs 0 immediately, no stale sample after release.
